// File: rtl/branch_pkg.sv
// branch_pkg: shared widths, queue entry type and PC-to-history-index helper for the branch resolve queue
package branch_pkg;
   localparam int BHT_IDX_W = 5;
   localparam int BRQ_PC_W = 32;
   typedef struct packed {
      logic [BRQ_PC_W-1:0] pc;
      logic                pred;
   } brq_entry_t;
   function automatic logic [BHT_IDX_W-1:0] pc_to_idx(input logic [BRQ_PC_W-1:0] pc);
      return pc[BHT_IDX_W+1:2];
   endfunction
endpackage

// File: rtl/brq_fifo.sv
// brq_fifo: circular storage with wrapping pointers, occupancy count and a synchronous clear that beats push/pop
module brq_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_wdata,
   output logic [W-1:0] o_rdata,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0] r_cnt;
   logic w_push, w_pop;
   assign o_full = r_cnt == (AW+1)'(DEPTH);
   assign o_empty = r_cnt == '0;
   assign w_push = i_push && !o_full;
   assign w_pop = i_pop && !o_empty;
   assign o_rdata = r_mem[r_rp];
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_wp <= '0;
         r_rp <= '0;
         r_cnt <= '0;
      end else begin
         r_wp <= r_wp + AW'(w_push);
         r_rp <= r_rp + AW'(w_pop);
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_wdata;
   end
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order predicted-branch queue; resolves oldest-first, drives BHT update and mispredict flush.
// Optional mispredict counter port enabled by defining BRQ_STATS_EN.
module branch_resolve_queue
   import branch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PC_W = BRQ_PC_W,
   parameter int IDX_W = BHT_IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic [PC_W-1:0]  push_pc,
   input  logic             push_pred,
   input  logic             res_valid,
   input  logic             res_taken,
   input  logic [PC_W-1:0]  res_target,
   output logic             flush,
   output logic [PC_W-1:0]  redirect_pc,
   output logic             bht_en,
   output logic [IDX_W-1:0] bht_addr,
   output logic             bht_taken,
   output logic             empty
`ifdef BRQ_STATS_EN
   ,output logic [15:0]     mispredict_cnt
`endif
);
   brq_entry_t w_head, w_wr;
   logic w_full, w_empty, w_res, w_mis;
   logic r_flush, r_bht_en, r_bht_taken;
   logic [PC_W-1:0] r_redirect;
   logic [IDX_W-1:0] r_bht_addr;
   assign w_wr = '{pc: push_pc, pred: push_pred};
   assign w_res = res_valid && !w_empty;
   assign w_mis = w_res && (res_taken != w_head.pred);
   // a mispredict clears the queue, which also discards any same-cycle push
   brq_fifo #(.DEPTH(DEPTH), .W($bits(brq_entry_t))) u_fifo (
      .clk(clk),
      .rst(rst),
      .i_clr(w_mis),
      .i_push(push_valid),
      .i_pop(w_res),
      .i_wdata(w_wr),
      .o_rdata(w_head),
      .o_full(w_full),
      .o_empty(w_empty)
   );
   assign push_ready = !w_full;
   assign empty = w_empty;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flush <= 1'b0;
         r_redirect <= '0;
         r_bht_en <= 1'b0;
         r_bht_addr <= '0;
         r_bht_taken <= 1'b0;
      end else begin
         r_flush <= w_mis;
         r_bht_en <= w_res;
         if (w_res) r_bht_addr <= pc_to_idx(w_head.pc);
         if (w_res) r_bht_taken <= res_taken;
         if (w_mis) r_redirect <= res_taken ? res_target : w_head.pc + PC_W'(4);
      end
   end
   assign flush = r_flush;
   assign redirect_pc = r_redirect;
   assign bht_en = r_bht_en;
   assign bht_addr = r_bht_addr;
   assign bht_taken = r_bht_taken;
`ifdef BRQ_STATS_EN
   logic [15:0] r_mis_cnt;
   always_ff @(posedge clk) begin
      if (rst) r_mis_cnt <= '0;
      else if (w_mis && r_mis_cnt != 16'hFFFF) r_mis_cnt <= r_mis_cnt + 16'd1;
   end
   assign mispredict_cnt = r_mis_cnt;
`endif
endmodule
